handshake_protocol_monitor: RTL and testbench
=============================================

Name: handshake_protocol_monitor

Overview:
- Parametrised, bind-able checker for N_CHAN ready/valid channels, each carrying DATA_W data bits.
- Successor to the single-purpose handshake assertion monitors. It tracks per-channel protocol state across cycles: valid dropped while stalled, data changed while stalled, stall timeout.
- Keeps saturating transfer counters and sticky error flags, and records the first error seen.
- Observation-only: bound into the DUT next to the channels, with no effect on DUT behaviour.

Parameters:
- N_CHAN, 3, number of monitored handshake channels (>=1).
- DATA_W, 5, payload width per channel (>=1).
- CNT_W, 16, width of each transfer counter.
- MAX_STALL, 8, consecutive valid&!ready cycles that constitute a timeout (>=2).
- CHAN_W, max(1,$clog2(N_CHAN)), channel index width (derived).

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- clear  in  1  synchronous clear of counters, errors and first-error record; lower priority than RESET.
- valid  in  N_CHAN  per-channel valid.
- ready  in  N_CHAN  per-channel ready.
- data  in  N_CHAN*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
- xfer_count  out  N_CHAN*CNT_W  per-channel saturating count of fires.
- err_drop  out  N_CHAN  sticky flag: valid deasserted while stalled.
- err_data  out  N_CHAN  sticky flag: data changed while stalled.
- err_timeout  out  N_CHAN  sticky flag: stall reached MAX_STALL.
- err_any  out  1  OR of all sticky flags.
- first_err_chan  out  CHAN_W  channel of the first recorded error.
- first_err_code  out  2  code of the first error: 0 none, 1 drop, 2 data, 3 timeout.

Behaviour:
- Definitions per channel i: fire = valid&ready; stall = valid&!ready.
- Per-channel FSM has two states, IDLE and WAIT. Both are reached from reset and from clear.
- IDLE:
  - stall -> go to WAIT, capture data into held_data, set stall_cnt=1.
  - fire or !valid -> stay in IDLE.
- WAIT:
  - !valid -> set err_drop, go to IDLE, stall_cnt=0.
  - valid && data!=held_data -> set err_data. The state transition is unaffected by this check.
  - fire -> go to IDLE, stall_cnt=0.
  - stall -> stay in WAIT, stall_cnt increments and saturates at MAX_STALL.
- Timeout:
  - err_timeout sets on the edge ending the MAX_STALL-th consecutive stall cycle (stall_cnt==MAX_STALL-1 and stall).
  - It fires once per stall episode.
  - A stall of exactly MAX_STALL-1 cycles followed by a fire produces no timeout.
- Data comparison covers only cycles with valid high. The value on the fire cycle itself is compared: a change on that cycle is an err_data.
- Error latency: every flag is registered and goes high one cycle after the offending cycle. Flags stay high until RESET or clear.
- xfer_count[i]:
  - increments on each fire, in any FSM state, visible the next cycle;
  - saturates at 2^CNT_W-1 and does not wrap.
- First-error record:
  - Loaded only when err_any is 0 before the edge and at least one new error occurs in that cycle.
  - If several errors occur in that cycle, the lowest channel index wins.
  - Within one channel, priority is drop(1) > data(2) > timeout(3).
  - Once loaded, the record holds until RESET or clear.
- Reset values (RESET or clear): all counters 0, all flags 0, err_any 0, first_err_chan 0, first_err_code 0, FSMs in IDLE, held_data 0.
- RESET mid-stall: the channel returns to IDLE. If valid is still high and ready low on the first post-reset cycle, that cycle starts a new episode with stall_cnt=1. No error is raised for the pre-reset history.
- RESET and clear asserted together behave as RESET.
- Channels are fully independent. The monitor has no outputs toward the DUT and never backpressures it.

Test Plan:
- Defaults; ch0 fires 4 times back-to-back with ready=1 -> xfer_count[0]=4, all flags 0, first_err_code=0.
- ch1: valid=1, data=5'h0A, ready=0 for 3 cycles, then ready=1 with data unchanged -> xfer_count[1]=1, no errors. Repeat with data=5'h0B on cycle 2 -> err_data[1]=1 next cycle, first_err_chan=1, first_err_code=2.
- ch2 stalls exactly 8 cycles -> err_timeout[2] rises after the 8th stall cycle. A separate episode stalling 7 cycles then firing -> no timeout.
- Same cycle: ch0 drops valid mid-stall while ch2 changes data mid-stall -> err_drop[0]=1, err_data[2]=1, first_err_chan=0, first_err_code=1.
- CNT_W=3, 10 fires on ch0 -> xfer_count[0] saturates at 7. Then pulse clear -> counters, flags and the first-error record all return to 0 the next cycle.
- RESET asserted on the 4th cycle of a ch1 stall with valid held high -> ch1 returns to IDLE; a timeout fires only after 8 further stall cycles following reset release.

Source files
------------

// File: rtl/handshake_protocol_monitor_if.sv
// Ready/valid channel bundle observed by handshake_protocol_monitor.
// The monitor modport is input-only so a bound checker can never drive the bus.
interface handshake_protocol_monitor_if #(
  parameter int N_CHAN = 3,
  parameter int DATA_W = 5
) ();
  logic [N_CHAN-1:0]        valid;
  logic [N_CHAN-1:0]        ready;
  logic [N_CHAN*DATA_W-1:0] data;

  modport master  (output valid, output data, input  ready);
  modport slave   (input  valid, input  data, output ready);
  modport monitor (input  valid, input  ready, input data);
endinterface

// File: rtl/handshake_protocol_monitor.sv
// Passive per-channel ready/valid protocol checker: transfer counters, sticky
// drop/data/timeout flags and a record of the first error observed.
module handshake_protocol_monitor #(
  parameter  int N_CHAN    = 3,
  parameter  int DATA_W    = 5,
  parameter  int CNT_W     = 16,
  parameter  int MAX_STALL = 8,
  localparam int CHAN_W    = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      clear,
  handshake_protocol_monitor_if.monitor hs,
  output logic [N_CHAN*CNT_W-1:0]   xfer_count,
  output logic [N_CHAN-1:0]         err_drop,
  output logic [N_CHAN-1:0]         err_data,
  output logic [N_CHAN-1:0]         err_timeout,
  output logic                      err_any,
  output logic [CHAN_W-1:0]         first_err_chan,
  output logic [1:0]                first_err_code
);

  localparam int SC_W = $clog2(MAX_STALL + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  logic [N_CHAN-1:0] new_drop;
  logic [N_CHAN-1:0] new_data;
  logic [N_CHAN-1:0] new_to;

  genvar gi;
  generate
    for (gi = 0; gi < N_CHAN; gi++) begin : g_chan
      state_e              state_q;
      logic [DATA_W-1:0]   held_q;
      logic [SC_W-1:0]     stall_cnt_q;
      logic [CNT_W-1:0]    cnt_q;
      logic                drop_q;
      logic                data_q;
      logic                to_q;
      logic                v;
      logic                r;
      logic [DATA_W-1:0]   d;
      logic                stall;
      logic                fire;

      assign v     = hs.valid[gi];
      assign r     = hs.ready[gi];
      assign d     = hs.data[gi*DATA_W +: DATA_W];
      assign stall = v & ~r;
      assign fire  = v & r;

      // Errors only exist while an episode is open; the fire cycle is still compared.
      assign new_drop[gi] = (state_q == WAIT) && !v;
      assign new_data[gi] = (state_q == WAIT) && v && (d != held_q);
      assign new_to[gi]   = (state_q == WAIT) && stall &&
                            (stall_cnt_q == SC_W'(MAX_STALL - 1));

      always_ff @(posedge CLK) begin
        if (RESET || clear) begin
          state_q     <= IDLE;
          held_q      <= '0;
          stall_cnt_q <= '0;
          cnt_q       <= '0;
          drop_q      <= 1'b0;
          data_q      <= 1'b0;
          to_q        <= 1'b0;
        end else begin
          if (fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (new_drop[gi]) drop_q <= 1'b1;
          if (new_data[gi]) data_q <= 1'b1;
          if (new_to[gi])   to_q   <= 1'b1;

          case (state_q)
            IDLE: begin
              if (stall) begin
                state_q     <= WAIT;
                held_q      <= d;
                stall_cnt_q <= SC_W'(1);
              end
            end
            WAIT: begin
              if (!v || r) begin
                state_q     <= IDLE;
                stall_cnt_q <= '0;
              end else if (stall_cnt_q != SC_W'(MAX_STALL)) begin
                stall_cnt_q <= stall_cnt_q + SC_W'(1);
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end

      assign xfer_count[gi*CNT_W +: CNT_W] = cnt_q;
      assign err_drop[gi]                  = drop_q;
      assign err_data[gi]                  = data_q;
      assign err_timeout[gi]               = to_q;
    end
  endgenerate

  assign err_any = |{err_drop, err_data, err_timeout};

  logic              first_hit_d;
  logic [CHAN_W-1:0] first_chan_d;
  logic [1:0]        first_code_d;
  logic [CHAN_W-1:0] first_chan_q;
  logic [1:0]        first_code_q;

  // Scan high to low so the lowest erroring channel is the one left standing.
  always_comb begin
    first_hit_d  = 1'b0;
    first_chan_d = '0;
    first_code_d = 2'd0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (new_drop[i] || new_data[i] || new_to[i]) begin
        first_hit_d  = 1'b1;
        first_chan_d = CHAN_W'(i);
        if (new_drop[i])      first_code_d = 2'd1;
        else if (new_data[i]) first_code_d = 2'd2;
        else                  first_code_d = 2'd3;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      first_chan_q <= '0;
      first_code_q <= 2'd0;
    end else if (!err_any && first_hit_d) begin
      first_chan_q <= first_chan_d;
      first_code_q <= first_code_d;
    end
  end

  assign first_err_chan = first_chan_q;
  assign first_err_code = first_code_q;

endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// Directed scoreboard bench: stimulus pushes hand-computed expectations tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_handshake_protocol_monitor;

  localparam int N    = 3;
  localparam int DW   = 5;
  localparam int CW   = 16;
  localparam int SCW  = 3;
  localparam int CHW  = 2;

  localparam int S_XFER = 0;
  localparam int S_DROP = 1;
  localparam int S_DATA = 2;
  localparam int S_TO   = 3;
  localparam int S_ANY  = 4;
  localparam int S_CHAN = 5;
  localparam int S_CODE = 6;
  localparam int S_SAT  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clr;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  handshake_protocol_monitor_if #(.N_CHAN(N), .DATA_W(DW)) hs ();

  logic [N*CW-1:0]  xfer_count;
  logic [N-1:0]     err_drop, err_data, err_timeout;
  logic             err_any;
  logic [CHW-1:0]   first_err_chan;
  logic [1:0]       first_err_code;

  logic [N*SCW-1:0] s_xfer_count;
  logic [N-1:0]     s_err_drop, s_err_data, s_err_timeout;
  logic             s_err_any;
  logic [CHW-1:0]   s_first_err_chan;
  logic [1:0]       s_first_err_code;

  handshake_protocol_monitor #(.N_CHAN(N), .DATA_W(DW), .CNT_W(CW), .MAX_STALL(8)) dut (
    .CLK(clk), .RESET(rst), .clear(clr), .hs(hs.monitor),
    .xfer_count(xfer_count), .err_drop(err_drop), .err_data(err_data),
    .err_timeout(err_timeout), .err_any(err_any),
    .first_err_chan(first_err_chan), .first_err_code(first_err_code)
  );

  handshake_protocol_monitor #(.N_CHAN(N), .DATA_W(DW), .CNT_W(SCW), .MAX_STALL(8)) dut_sat (
    .CLK(clk), .RESET(rst), .clear(clr), .hs(hs.monitor),
    .xfer_count(s_xfer_count), .err_drop(s_err_drop), .err_data(s_err_data),
    .err_timeout(s_err_timeout), .err_any(s_err_any),
    .first_err_chan(s_first_err_chan), .first_err_code(s_first_err_code)
  );

  typedef struct {
    int          cyc;
    int          sel;
    int          ch;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic string sel_name(input int sel);
    case (sel)
      S_XFER:  return "xfer_count";
      S_DROP:  return "err_drop";
      S_DATA:  return "err_data";
      S_TO:    return "err_timeout";
      S_ANY:   return "err_any";
      S_CHAN:  return "first_err_chan";
      S_CODE:  return "first_err_code";
      default: return "sat_xfer_count";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int sel, input int ch);
    case (sel)
      S_XFER:  return 32'(xfer_count[ch*CW +: CW]);
      S_DROP:  return 32'(err_drop);
      S_DATA:  return 32'(err_data);
      S_TO:    return 32'(err_timeout);
      S_ANY:   return 32'(err_any);
      S_CHAN:  return 32'(first_err_chan);
      S_CODE:  return 32'(first_err_code);
      default: return 32'(s_xfer_count[ch*SCW +: SCW]);
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.sel, e.ch);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s ch%0d cyc%0d got %0h want %0h", sel_name(e.sel), e.ch, cyc, a, e.exp);
      end else begin
        $display("ok   %s ch%0d cyc%0d = %0h", sel_name(e.sel), e.ch, cyc, a);
      end
    end
  end

  // dly=0: state visible now; dly=1: state after the coming edge
  task automatic push(input int dly, input int sel, input int ch, input logic [31:0] e);
    exp_t x;
    x.cyc = cyc + dly;
    x.sel = sel;
    x.ch  = ch;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic push_zero(input int dly);
    for (int c = 0; c < N; c++) push(dly, S_XFER, c, 0);
    push(dly, S_DROP, 0, 0);
    push(dly, S_DATA, 0, 0);
    push(dly, S_TO,   0, 0);
    push(dly, S_ANY,  0, 0);
    push(dly, S_CHAN, 0, 0);
    push(dly, S_CODE, 0, 0);
    push(dly, S_SAT,  0, 0);
  endtask

  function automatic logic [N*DW-1:0] pack(input logic [DW-1:0] d0, d1, d2);
    return {d2, d1, d0};
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] r, input logic [N*DW-1:0] d);
    hs.valid = v;
    hs.ready = r;
    hs.data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    drive(3'b000, 3'b000, '0);
    clr = 1'b1;
    push_zero(1);
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    drive(3'b000, 3'b000, '0);
    tick();
    tick();
    rst = 1'b0;
    push_zero(0);

    // ch0 four back-to-back fires
    drive(3'b001, 3'b001, pack(5'h01, 5'h00, 5'h00));
    push(1, S_XFER, 0, 1);
    repeat (4) tick();
    drive(3'b000, 3'b000, '0);
    push(0, S_XFER, 0, 4);
    push(0, S_ANY,  0, 0);
    push(0, S_CODE, 0, 0);
    push(0, S_SAT,  0, 4);
    tick();

    // ch1 clean 3-cycle stall then fire
    drive(3'b010, 3'b000, pack(5'h00, 5'h0A, 5'h00));
    repeat (3) tick();
    drive(3'b010, 3'b010, pack(5'h00, 5'h0A, 5'h00));
    push(1, S_XFER, 1, 1);
    push(1, S_ANY,  0, 0);
    push(1, S_DATA, 0, 0);
    tick();
    drive(3'b000, 3'b000, '0);
    tick();

    // ch1 data changes on the 2nd stall cycle
    drive(3'b010, 3'b000, pack(5'h00, 5'h0A, 5'h00));
    tick();
    drive(3'b010, 3'b000, pack(5'h00, 5'h0B, 5'h00));
    push(0, S_DATA, 0, 0);
    push(1, S_DATA, 0, 3'b010);
    push(1, S_ANY,  0, 1);
    push(1, S_CHAN, 0, 1);
    push(1, S_CODE, 0, 2);
    tick();
    drive(3'b010, 3'b010, pack(5'h00, 5'h0B, 5'h00));
    push(1, S_XFER, 1, 2);
    tick();
    pulse_clear();

    // ch2 stalls exactly 8 cycles
    drive(3'b100, 3'b000, pack(5'h00, 5'h00, 5'h11));
    for (int k = 1; k <= 8; k++) begin
      if (k == 7) push(1, S_TO, 0, 0);
      if (k == 8) begin
        push(1, S_TO,   0, 3'b100);
        push(1, S_CHAN, 0, 2);
        push(1, S_CODE, 0, 3);
      end
      tick();
    end
    drive(3'b100, 3'b100, pack(5'h00, 5'h00, 5'h11));
    push(1, S_XFER, 2, 1);
    tick();
    pulse_clear();

    // ch2 stalls 7 cycles then fires: no timeout
    drive(3'b100, 3'b000, pack(5'h00, 5'h00, 5'h12));
    repeat (7) tick();
    drive(3'b100, 3'b100, pack(5'h00, 5'h00, 5'h12));
    push(1, S_TO,   0, 0);
    push(1, S_ANY,  0, 0);
    push(1, S_XFER, 2, 1);
    tick();

    // same cycle: ch0 drops, ch2 changes data
    drive(3'b101, 3'b000, pack(5'h03, 5'h00, 5'h07));
    tick();
    drive(3'b100, 3'b000, pack(5'h00, 5'h00, 5'h08));
    push(1, S_DROP, 0, 3'b001);
    push(1, S_DATA, 0, 3'b100);
    push(1, S_CHAN, 0, 0);
    push(1, S_CODE, 0, 1);
    tick();
    drive(3'b100, 3'b100, pack(5'h00, 5'h00, 5'h08));
    push(1, S_XFER, 2, 2);
    tick();
    // later ch1 drop must not overwrite the first-error record
    drive(3'b010, 3'b000, pack(5'h00, 5'h04, 5'h00));
    tick();
    drive(3'b000, 3'b000, '0);
    push(1, S_DROP, 0, 3'b011);
    push(1, S_CHAN, 0, 0);
    push(1, S_CODE, 0, 1);
    tick();
    pulse_clear();

    // 10 fires on ch0: narrow counter saturates at 7
    drive(3'b001, 3'b001, pack(5'h02, 5'h00, 5'h00));
    for (int k = 1; k <= 10; k++) begin
      if (k == 7 || k == 8 || k == 10) push(1, S_SAT, 0, 7);
      tick();
    end
    drive(3'b000, 3'b000, '0);
    push(0, S_XFER, 0, 10);
    tick();
    pulse_clear();

    // RESET on the 4th cycle of a ch1 stall, valid held high
    drive(3'b010, 3'b000, pack(5'h00, 5'h15, 5'h00));
    repeat (3) tick();
    rst = 1'b1;
    push_zero(1);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 5 || k == 7) push(1, S_TO, 0, 0);
      if (k == 8) begin
        push(1, S_TO,   0, 3'b010);
        push(1, S_CHAN, 0, 1);
        push(1, S_CODE, 0, 3);
      end
      tick();
    end
    drive(3'b010, 3'b010, pack(5'h00, 5'h15, 5'h00));
    push(1, S_XFER, 1, 1);
    tick();
    drive(3'b000, 3'b000, '0);
    tick();

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
